hack_mmio_responder: RTL

- Responder end of the Hack CPU data-memory bus. It takes the CPU's address, write enable and write data, and returns read data on the same cycle.
- Decodes the Hack memory map:
  - 16K-word data RAM.
  - Screen region, with writes buffered to a display controller through a valid/ready FIFO and reads served from an internal shadow.
  - Keyboard register, fed by a key-event handshake.
- Replaces the flat data RAM behind the CPU in the top-level platform.

---
 rtl/hack_mmio_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/hack_mmio_responder.sv
// Hack CPU data-memory responder. It holds the data RAM, a screen shadow with a
// buffered write path to the display controller, and the keyboard register.
module hack_mmio_responder #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned RAM_WORDS      = 16384,
  parameter int unsigned SCR_WORDS      = 8192,
  parameter int unsigned SCR_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              stall,
  output logic              err,
  output logic              scr_valid,
  output logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_data,
  input  logic              scr_ready,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_code,
  output logic              key_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned SCR_AW = $clog2(SCR_WORDS);
  localparam int unsigned PTR_W  = $clog2(SCR_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [DATA_W-1:0] ram    [RAM_WORDS];
  logic [DATA_W-1:0] shadow [SCR_WORDS];
  logic [12:0]       fifo_addr [SCR_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [SCR_FIFO_DEPTH];

  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0] kbd_reg;
  logic              is_ram, is_scr, is_kbd;
  logic              fifo_empty, fifo_full;
  logic              pop, scr_req, push;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;

  assign is_ram  = (address[15:14] == 2'b00);
  assign is_scr  = (address[15:13] == 3'b010);
  assign is_kbd  = (address == 16'h6000);
  assign ram_idx = address[RAM_AW-1:0];
  assign scr_idx = address[SCR_AW-1:0];

  // Wrap bit differs with equal index bits -> full; identical pointers -> empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign scr_valid = !fifo_empty;
  assign scr_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign scr_data  = fifo_data[rd_ptr[PTR_W-1:0]];
  assign pop       = scr_valid && scr_ready;
  assign scr_req   = load && is_scr;
  assign push      = scr_req && (!fifo_full || pop);
  assign stall     = scr_req && !push;
  assign key_ready = reset;

  always_comb begin
    out = '0;
    if (is_ram)      out = ram[ram_idx];
    else if (is_scr) out = shadow[scr_idx];
    else if (is_kbd) out = kbd_reg;
  end

  always_ff @(posedge clk) begin
    if (load && is_ram) ram[ram_idx] <= in;
    if (push)           shadow[scr_idx] <= in;
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= address[12:0];
      fifo_data[wr_ptr[PTR_W-1:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      kbd_reg <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (key_valid && key_ready) kbd_reg <= key_code;
      err <= load && !is_ram && !is_scr;
    end
  end

endmodule
